// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch stage and the main decoder.
//   fetch_state_t : fetch FSM encoding (S_REQ / S_WAIT / S_DROP)
//   fetch_entry_t : {instr, pc} pair carried by the IF/ID slot and skid buffer
//   OPCODE_MSB/LSB: opcode field location inside an instruction word
//   word_align()  : force an address onto a 4-byte boundary
package core_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a request for the current PC
    S_WAIT = 2'd1,  // one request outstanding, response is on the good path
    S_DROP = 2'd2   // one request outstanding, response is wrong-path
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: single-entry holding register for a fetched {instr, pc}
// that arrives while the IF/ID slot is occupied and stalled.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : drop any held entry (wins over load/unload)
//   load        : capture load_entry
//   unload      : entry has been moved out; may coincide with load
//   load_entry  : incoming {instr, pc}
//   full        : an entry is held
//   entry       : held {instr, pc}
module fetch_skid_buffer
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  fetch_entry_t load_entry,
  output logic         full,
  output fetch_entry_t entry
);

  logic         full_q, full_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (flush) begin
      full_d = 1'b0;
    end else begin
      if (unload) full_d = 1'b0;
      // Load after unload so a same-cycle unload+load leaves the buffer full.
      if (load) begin
        full_d  = 1'b1;
        entry_d = load_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full  = full_q;
  assign entry = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the MIPS core. Owns the PC, issues one
// word request at a time to instruction memory, and feeds a registered IF/ID
// slot to the decoder. Downstream redirects retarget the PC and squash any
// in-flight or buffered wrong-path instruction.
//   clk, reset                     : clock, synchronous active-high reset
//   imem_req_valid/ready/addr      : request channel (addr = aligned PC)
//   imem_resp_valid/data           : response, always accepted
//   redirect_valid/redirect_pc     : taken branch/jump target from downstream
//   if_valid/id_ready              : IF/ID slot handshake
//   if_instr/if_opcode/if_pc/if_pc_plus4 : slot contents
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;   // address of the outstanding request
  logic         if_valid_q, if_valid_d;
  fetch_entry_t slot_q, slot_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;

  logic         skid_full, skid_load, skid_unload, skid_flush;
  fetch_entry_t skid_entry, resp_entry, slot_src;
  logic         slot_load;
  logic         req_fire, resp_take, consume;

  // Requests stop once the skid buffer is full: there is nowhere left to put
  // another response. A redirect suppresses the request so the old PC is
  // never accepted in the redirect cycle.
  assign imem_req_valid = !reset && (state_q == S_REQ) && !skid_full && !redirect_valid;
  assign imem_req_addr  = word_align(pc_q);

  assign req_fire   = imem_req_valid && imem_req_ready;
  assign resp_take  = imem_resp_valid && (state_q == S_WAIT) && !redirect_valid;
  assign consume    = if_valid_q && id_ready;
  assign resp_entry = '{instr: imem_resp_data, pc: fetch_pc_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    if_valid_d  = if_valid_q;
    slot_d      = slot_q;
    pc_plus4_d  = pc_plus4_q;
    slot_load   = 1'b0;
    slot_src    = resp_entry;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (redirect_valid) begin
      pc_d       = word_align(redirect_pc);
      if_valid_d = 1'b0;
      skid_flush = 1'b1;
      case (state_q)
        // A response landing this cycle retires the outstanding request
        // (discarded); otherwise the one still in flight must be dropped.
        S_WAIT, S_DROP: state_d = imem_resp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      if (req_fire) begin
        pc_d       = pc_q + 32'd4;
        fetch_pc_d = imem_req_addr;
        state_d    = S_WAIT;
      end else if (imem_resp_valid && (state_q != S_REQ)) begin
        state_d = S_REQ;
      end

      if (consume) begin
        if (skid_full) begin
          // Older buffered instruction goes first.
          slot_load   = 1'b1;
          slot_src    = skid_entry;
          skid_unload = 1'b1;
          skid_load   = resp_take;
        end else if (resp_take) begin
          slot_load = 1'b1;
        end else begin
          if_valid_d = 1'b0;
        end
      end else if (resp_take) begin
        if (!if_valid_q) slot_load = 1'b1;
        else             skid_load = 1'b1;
      end

      if (slot_load) begin
        if_valid_d = 1'b1;
        slot_d     = slot_src;
        pc_plus4_d = slot_src.pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      if_valid_q <= 1'b0;
      slot_q     <= '0;
      pc_plus4_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid_q <= if_valid_d;
      slot_q     <= slot_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (skid_flush),
    .load       (skid_load),
    .unload     (skid_unload),
    .load_entry (resp_entry),
    .full       (skid_full),
    .entry      (skid_entry)
  );

  assign if_valid    = if_valid_q;
  assign if_instr    = slot_q.instr;
  assign if_opcode   = slot_q.instr[OPCODE_MSB:OPCODE_LSB];
  assign if_pc       = slot_q.pc;
  assign if_pc_plus4 = pc_plus4_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS core; sits directly upstream of the main decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel; one request outstanding at most.
- Presents a registered IF/ID slot (instruction, PC, PC+4, opcode field) to the decode stage under a valid/ready handshake.
- Applies branch/jump redirects from downstream and discards wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-high.
- imem_req_valid  out  1  fetch request presented.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address (current PC).
- imem_resp_valid  in  1  response data valid; must be accepted, no back-pressure.
- imem_resp_data  in  32  fetched instruction word.
- redirect_valid  in  1  taken beq/bne, j or jal from downstream.
- redirect_pc  in  32  redirect target; bits [1:0] ignored.
- if_valid  out  1  IF/ID slot holds a valid instruction.
- id_ready  in  1  decode stage consumes slot this cycle.
- if_instr  out  32  instruction word.
- if_opcode  out  6  if_instr[31:26]; feeds decoder opcode input.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset:
  - pc = RESET_PC; state = S_REQ.
  - if_valid = 0; if_instr, if_pc, if_pc_plus4 = 0.
  - Skid buffer empty; imem_req_valid = 0 during the reset cycle.
- Request and response timing:
  - imem_req_valid = (state == S_REQ) and skid buffer empty and not redirect_valid.
  - imem_req_addr = {pc[31:2], 2'b00}.
  - Request handshake (valid && ready): pc <= pc + 4 (0xFFFF_FFFC wraps to 0); record fetched pc; state <= S_WAIT.
  - Memory latency is at least 1 cycle; a response in the same cycle as its accept is illegal. Bench asserts this.
- States:
  - S_REQ: requesting.
  - S_WAIT: one request outstanding, awaiting response.
  - S_DROP: outstanding response is wrong-path; discard it.
- Transitions:
  - S_WAIT + resp → S_REQ.
  - S_DROP + resp → S_REQ, data discarded.
- Response capture:
  - If the slot is empty or being consumed (if_valid && id_ready), load the slot directly; if_valid = 1 next cycle.
  - Otherwise load the 1-entry skid buffer.
  - Latency: response at cycle N → if_valid at N+1.
- Slot consume (if_valid && id_ready):
  - Skid full: skid moves into slot.
  - Else if a response is arriving: it moves into slot.
  - Else if_valid <= 0.
- Stall: while if_valid && !id_ready, all if_* outputs hold stable.
- Redirect (highest priority over stall, response and request):
  - pc <= {redirect_pc[31:2], 2'b00}; if_valid <= 0; skid cleared.
  - In S_WAIT with no response this cycle → S_DROP.
  - In S_WAIT with response this cycle → response discarded, S_REQ.
  - In S_DROP → stays S_DROP.
  - In S_REQ → S_REQ (request suppressed this cycle, so no wrong-path accept).
  - The first request after a redirect is issued the next cycle at the target address.
- Redirect and id_ready in the same cycle: the slot is flushed. The decoder must treat its consumed instruction as the one that produced the redirect.
- Reset mid-operation (any state, outstanding request): returns to reset values. The bench must not deliver a response after reset for a pre-reset request.
- Throughput: one instruction per 2 cycles (accept, response) with single outstanding request.

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum {S_REQ, S_WAIT, S_DROP}.
  - OPCODE_MSB = 31, OPCODE_LSB = 26, shared with the main decoder.
  - INSTR_W = 32.
- Sub-module fetch_skid_buffer: 1-entry {instr, pc} buffer with load/unload/flush and full flag.
- Top handles the PC, FSM and slot mux.

Test Plan:
- Reset, then 0-latency-plus-1 memory, id_ready = 1 → addrs 0x0, 0x4, 0x8. if_valid pulses with if_pc 0x0/0x4/0x8 and if_opcode matching instr[31:26] (e.g. 0x8C01_0000 → 6'b100011).
- id_ready = 0 for 5 cycles after the first instr → slot holds 0x0, skid captures 0x4, no further requests. Release → 0x0 then 0x4 delivered in order, no loss or duplication.
- Redirect to 0x40 while in S_WAIT for 0x8 → the 0x8 response is dropped, the next request addr is 0x40, and the first if_pc after the redirect is 0x40.
- Redirect coincident with imem_resp_valid → response discarded, next cycle requests redirect_pc. redirect_pc = 0x43 → request addr 0x40.
- RESET_PC = 0xFFFF_FFFC → first fetch 0xFFFF_FFFC, if_pc_plus4 = 0, second fetch addr 0x0.
- imem_req_ready low for 3 cycles → req_valid held with stable addr and pc not incremented; assert reset mid-S_WAIT → state S_REQ, if_valid = 0, pc = RESET_PC.
